laser_sdram_arbiter: RTL and testbench

- Parametrised N-channel arbiter in front of the single-port `sdram` controller. Replaces the hard-wired download/VTL address-data mux.
- Each client (ROM download, VTL chip, CPU, future DMA/cassette) gets a req/ack handshake; the arbiter serialises accesses into fixed SDRAM slots locked to F14M.
- Supports fixed-priority or round-robin arbitration, plus a download lock that grants only channel 0.

---
 rtl/laser_sdram_pkg.sv | 22 ++
 rtl/sdram_rr_picker.sv | 35 +++
 rtl/laser_sdram_arbiter.sv | 151 +++++++++++++++
 tb/tb_laser_sdram_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_sdram_pkg.sv
// Shared types and constants for the SDRAM client arbiter and its picker.
package laser_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CH_DL  = 0;
  localparam int CH_VTL = 1;
  localparam int CH_CPU = 2;

  // Index width for n channels, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational request picker: lowest index, or first index after rr_last when rr_mode is set.
module sdram_rr_picker
  import laser_sdram_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int IW     = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     rr_last,
  input  logic              rr_mode,
  output logic [IW-1:0]     grant,
  output logic              valid
);

  int              start_idx;
  int              idx;
  logic [NUM_CH-1:0] req_rot;

  always_comb begin
    grant     = '0;
    valid     = 1'b0;
    idx       = 0;
    req_rot   = '0;
    start_idx = rr_mode ? int'(rr_last) + 1 : 0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx     = (start_idx + off) % NUM_CH;
      req_rot = req >> idx;
      if (!valid && req_rot[0]) begin
        valid = 1'b1;
        grant = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/laser_sdram_arbiter.sv
// N-channel req/ack arbiter serialising client accesses into fixed SDRAM slots on F14M.
module laser_sdram_arbiter
  import laser_sdram_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 8,
  parameter int RR_MODE     = 0,
  parameter int SLOT_CYCLES = 2
) (
  input  logic                     F14M,
  input  logic                     RESET,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_din,
  input  logic                     dl_lock,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [DATA_W-1:0]        ch_dout,
  output logic [ADDR_W-1:0]        sdram_addr,
  output logic [DATA_W-1:0]        sdram_din,
  output logic                     sdram_we,
  output logic                     sdram_oe,
  input  logic [DATA_W-1:0]        sdram_dout,
  output logic                     busy
);

  localparam int IW = clog2_min1(NUM_CH);
  localparam logic [NUM_CH-1:0] DL_MASK = NUM_CH'(1);

  // Handshake: a client holds ch_req (with stable we/addr/din) until it sees its
  // one-cycle ch_ack pulse; request fields are captured only at grant.
  state_t            state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     rr_last_q, rr_last_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              oe_q, oe_d;

  logic [NUM_CH-1:0] eligible;
  logic [IW-1:0]     pick_g;
  logic              pick_v;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic              sel_we;

  assign eligible = dl_lock ? (ch_req & DL_MASK) : ch_req;

  sdram_rr_picker #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_picker (
    .req     (eligible),
    .rr_last (rr_last_q),
    .rr_mode (RR_MODE != 0),
    .grant   (pick_g),
    .valid   (pick_v)
  );

  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_we   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_g == IW'(i)) begin
        sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
        sel_din  = ch_din[i*DATA_W +: DATA_W];
        sel_we   = ch_we[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    dout_d    = dout_q;
    addr_d    = addr_q;
    din_d     = din_q;
    we_d      = we_q;
    oe_d      = oe_q;
    case (state_q)
      IDLE: begin
        if (pick_v) begin
          state_d = ISSUE;
          grant_d = pick_g;
          cnt_d   = 3'(SLOT_CYCLES - 1);
          addr_d  = sel_addr;
          din_d   = sel_din;
          we_d    = sel_we;
          oe_d    = ~sel_we;
        end
      end
      ISSUE: begin
        if (cnt_q == 3'd0) begin
          state_d   = DONE;
          we_d      = 1'b0;
          oe_d      = 1'b0;
          ack_d     = NUM_CH'(1) << grant_q;
          rr_last_d = grant_q;
          if (oe_q) dout_d = sdram_dout;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge F14M) begin
    if (RESET) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_last_q <= IW'(NUM_CH - 1);
      cnt_q     <= '0;
      ack_q     <= '0;
      dout_q    <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      oe_q      <= oe_d;
    end
  end

  assign ch_ack     = ack_q;
  assign ch_dout    = dout_q;
  assign sdram_addr = addr_q;
  assign sdram_din  = din_q;
  assign sdram_we   = we_q;
  assign sdram_oe   = oe_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_laser_sdram_arbiter.sv
// Bench for laser_sdram_arbiter: three instances (fixed/slot2, round-robin/slot2, fixed/slot1)
// checked every cycle against a timestamp-based transaction model plus literal expectations.
module tb_laser_sdram_arbiter;

  localparam int N  = 3;
  localparam int AW = 25;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req_v   [3];
  logic [N-1:0]    ch_we;
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_din;
  logic            dl_lock;
  logic [DW-1:0]   sd_dout;

  logic [N-1:0]  ack_v  [3];
  logic [DW-1:0] dout_v [3];
  logic [AW-1:0] sa_v   [3];
  logic [DW-1:0] sdin_v [3];
  logic          swe_v  [3];
  logic          soe_v  [3];
  logic          busy_v [3];

  laser_sdram_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .SLOT_CYCLES(2)) dut0 (
    .F14M(clk), .RESET(rst), .ch_req(req_v[0]), .ch_we(ch_we), .ch_addr(ch_addr), .ch_din(ch_din),
    .dl_lock(dl_lock), .ch_ack(ack_v[0]), .ch_dout(dout_v[0]), .sdram_addr(sa_v[0]),
    .sdram_din(sdin_v[0]), .sdram_we(swe_v[0]), .sdram_oe(soe_v[0]), .sdram_dout(sd_dout),
    .busy(busy_v[0]));

  laser_sdram_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .SLOT_CYCLES(2)) dut1 (
    .F14M(clk), .RESET(rst), .ch_req(req_v[1]), .ch_we(ch_we), .ch_addr(ch_addr), .ch_din(ch_din),
    .dl_lock(dl_lock), .ch_ack(ack_v[1]), .ch_dout(dout_v[1]), .sdram_addr(sa_v[1]),
    .sdram_din(sdin_v[1]), .sdram_we(swe_v[1]), .sdram_oe(soe_v[1]), .sdram_dout(sd_dout),
    .busy(busy_v[1]));

  laser_sdram_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .SLOT_CYCLES(1)) dut2 (
    .F14M(clk), .RESET(rst), .ch_req(req_v[2]), .ch_we(ch_we), .ch_addr(ch_addr), .ch_din(ch_din),
    .dl_lock(dl_lock), .ch_ack(ack_v[2]), .ch_dout(dout_v[2]), .sdram_addr(sa_v[2]),
    .sdram_din(sdin_v[2]), .sdram_we(swe_v[2]), .sdram_oe(soe_v[2]), .sdram_dout(sd_dout),
    .busy(busy_v[2]));

  // ---------------- scoreboard bookkeeping ----------------
  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [7:0] exp_q [$];
  int ack_d [$];
  int ack_c [$];
  int ack_t [$];

  int want [3][N];
  int got  [3][N];

  function automatic int slot_of(input int d);
    return (d == 2) ? 1 : 2;
  endfunction

  function automatic bit rr_of(input int d);
    return (d == 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_act  [3];
  int            m_t0   [3];
  int            m_g    [3];
  logic          m_we   [3];
  logic [AW-1:0] m_addr [3];
  logic [DW-1:0] m_din  [3];
  logic [DW-1:0] m_dout [3];
  int            m_last [3];

  // Grant rule: lock keeps only channel 0; fixed = lowest index, RR = first after last grant.
  function automatic int pick(input logic [N-1:0] r, input bit lock, input bit rr, input int last);
    logic [N-1:0] e;
    e = lock ? (r & 3'b001) : r;
    if (e == '0) return -1;
    if (!rr) begin
      for (int i = 0; i < N; i++) if (e[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (e[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_act[d] = 1'b0; m_t0[d] = 0; m_g[d] = 0; m_we[d] = 1'b0;
      m_addr[d] = '0; m_din[d] = '0; m_dout[d] = '0; m_last[d] = N - 1;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          m_act[d] = 1'b0; m_we[d] = 1'b0;
          m_addr[d] = '0; m_din[d] = '0; m_dout[d] = '0; m_last[d] = N - 1;
        end else if (m_act[d]) begin
          if (cyc == m_t0[d] + slot_of(d)) begin
            if (!m_we[d]) m_dout[d] = sd_dout;
            m_last[d] = m_g[d];
          end else if (cyc == m_t0[d] + slot_of(d) + 1) begin
            m_act[d] = 1'b0;
          end
        end else begin
          int g;
          g = pick(req_v[d], dl_lock, rr_of(d), m_last[d]);
          if (g >= 0) begin
            m_act[d]  = 1'b1;
            m_t0[d]   = cyc;
            m_g[d]    = g;
            m_we[d]   = ch_we[g];
            m_addr[d] = ch_addr[g*AW +: AW];
            m_din[d]  = ch_din[g*DW +: DW];
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int d = 0; d < 3; d++) begin
          int            ph;
          logic          strobe;
          logic [N-1:0]  e_ack;
          ph     = cyc - m_t0[d];
          strobe = m_act[d] && (ph < slot_of(d));
          e_ack  = (m_act[d] && ph == slot_of(d)) ? (3'b001 << m_g[d]) : 3'b000;
          chk($sformatf("d%0d_ack", d),  64'(ack_v[d]),  64'(e_ack));
          chk($sformatf("d%0d_we", d),   64'(swe_v[d]),  64'(strobe & m_we[d]));
          chk($sformatf("d%0d_oe", d),   64'(soe_v[d]),  64'(strobe & ~m_we[d]));
          chk($sformatf("d%0d_busy", d), 64'(busy_v[d]), 64'(m_act[d]));
          chk($sformatf("d%0d_addr", d), 64'(sa_v[d]),   64'(m_addr[d]));
          chk($sformatf("d%0d_din", d),  64'(sdin_v[d]), 64'(m_din[d]));
          chk($sformatf("d%0d_dout", d), 64'(dout_v[d]), 64'(m_dout[d]));
        end
      end
    end
  end

  // ---------------- client driver / ack monitor ----------------
  initial begin
    for (int d = 0; d < 3; d++) req_v[d] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        for (int c = 0; c < N; c++) begin
          if (ack_v[d][c]) begin
            req_v[d][c] = 1'b0;
            got[d][c]++;
            ack_d.push_back(d);
            ack_c.push_back(c);
            ack_t.push_back(cyc);
          end else if (!req_v[d][c] && got[d][c] < want[d][c]) begin
            req_v[d][c] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic wait_done(input int d, input string name);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      n++;
      ok = !busy_v[d];
      for (int c = 0; c < N; c++) if (got[d][c] < want[d][c]) ok = 1'b0;
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  task automatic check_order(input int d, input int from, input string name);
    logic [7:0] got_q [$];
    for (int i = from; i < ack_d.size(); i++) if (ack_d[i] == d) got_q.push_back(8'(ack_c[i]));
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int from;
    int n;
    dl_lock = 1'b0;
    ch_we   = '0;
    ch_addr = '0;
    ch_din  = '0;
    sd_dout = '0;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_busy", 64'(busy_v[0]), 64'd0);
    chk("rst_ack",  64'(ack_v[1]),  64'd0);
    chk("rst_addr", 64'(sa_v[2]),   64'd0);
    chk("rst_dout", 64'(dout_v[0]), 64'd0);

    // single read on channel 1
    ch_addr[1*AW +: AW] = 25'h1C000;
    sd_dout = 8'hF3;
    want[0][1]++;
    @(negedge clk);
    chk("rd_wait_busy", 64'(busy_v[0]), 64'd0);
    @(negedge clk);
    chk("rd_oe1",   64'(soe_v[0]), 64'd1);
    chk("rd_we1",   64'(swe_v[0]), 64'd0);
    chk("rd_addr",  64'(sa_v[0]),  64'h1C000);
    @(negedge clk);
    chk("rd_oe2",   64'(soe_v[0]), 64'd1);
    @(negedge clk);
    chk("rd_ack",   64'(ack_v[0]),  64'b010);
    chk("rd_oe3",   64'(soe_v[0]),  64'd0);
    chk("rd_dout",  64'(dout_v[0]), 64'hF3);
    @(negedge clk);
    chk("rd_ack_end", 64'(ack_v[0]),  64'd0);
    chk("rd_idle",    64'(busy_v[0]), 64'd0);

    // fixed priority, all three requesting
    ch_addr[0*AW +: AW] = 25'h100;
    ch_addr[1*AW +: AW] = 25'h200;
    ch_addr[2*AW +: AW] = 25'h300;
    sd_dout = 8'h5A;
    from = ack_d.size();
    want[0][0] += 2; want[0][1] += 2; want[0][2] += 1;
    wait_done(0, "fp_done");
    exp_q = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
    check_order(0, from, "fp_order");

    // round-robin, all three requesting continuously
    from = ack_d.size();
    want[1][0] += 2; want[1][1] += 2; want[1][2] += 2;
    wait_done(1, "rr_done");
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
    check_order(1, from, "rr_order");

    // download lock: ch1/ch2 wait while ch0 writes
    dl_lock = 1'b1;
    ch_we = 3'b001;
    ch_addr[0*AW +: AW] = 25'h3800;
    ch_din[0*DW +: DW]  = 8'h41;
    from = ack_d.size();
    want[0][1]++; want[0][2]++;
    repeat (4) @(negedge clk);
    chk("dl_blocked_busy", 64'(busy_v[0]), 64'd0);
    chk("dl_blocked_ack",  64'(ack_v[0]),  64'd0);
    want[0][0]++;
    @(negedge clk);
    @(negedge clk);
    chk("dl_we1",   64'(swe_v[0]),  64'd1);
    chk("dl_oe1",   64'(soe_v[0]),  64'd0);
    chk("dl_din",   64'(sdin_v[0]), 64'h41);
    chk("dl_addr",  64'(sa_v[0]),   64'h3800);
    @(negedge clk);
    chk("dl_we2",   64'(swe_v[0]),  64'd1);
    @(negedge clk);
    chk("dl_ack",   64'(ack_v[0]),  64'b001);
    chk("dl_we3",   64'(swe_v[0]),  64'd0);
    repeat (4) @(negedge clk);
    chk("dl_still_blocked", 64'(busy_v[0]), 64'd0);
    dl_lock = 1'b0;
    wait_done(0, "dl_done");
    exp_q = '{8'd0, 8'd1, 8'd2};
    check_order(0, from, "dl_order");

    // reset in the middle of channel 2's slot
    ch_we = 3'b000;
    ch_addr[2*AW +: AW] = 25'h2222;
    sd_dout = 8'h77;
    from = ack_d.size();
    want[0][2]++;
    n = 0;
    while (!busy_v[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rs_granted", 64'(busy_v[0]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rs_we",   64'(swe_v[0]),  64'd0);
    chk("rs_oe",   64'(soe_v[0]),  64'd0);
    chk("rs_ack",  64'(ack_v[0]),  64'd0);
    chk("rs_busy", 64'(busy_v[0]), 64'd0);
    chk("rs_addr", 64'(sa_v[0]),   64'd0);
    wait_done(0, "rs_done");
    exp_q = '{8'd2};
    check_order(0, from, "rs_order");
    chk("rs_dout", 64'(dout_v[0]), 64'h77);

    // back-to-back writes on the single-cycle-slot instance
    ch_we = 3'b010;
    ch_addr[1*AW +: AW] = 25'h0;
    ch_din[1*DW +: DW]  = 8'hA5;
    from = ack_d.size();
    want[2][1] += 2;
    n = 0;
    while (got[2][1] < want[2][1] - 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ch_addr[1*AW +: AW] = 25'h1;
    ch_din[1*DW +: DW]  = 8'hA6;
    wait_done(2, "bb_done");
    exp_q = '{8'd1, 8'd1};
    check_order(2, from, "bb_order");
    if (ack_t.size() >= 2)
      chk("bb_spacing", 64'(ack_t[ack_t.size()-1] - ack_t[ack_t.size()-2]), 64'd3);
    chk("bb_dout_kept", 64'(dout_v[2]), 64'd0);
    chk("bb_last_addr", 64'(sa_v[2]),   64'h1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
